// File: rtl/usb_tx_line_driver_if.sv
// usb_tx_line_driver_if
//   Bundles the packet handshake and pad-side signals of the USB transmit
//   line driver.
//   master : upstream (NRZI encoder / bit-stuffer side); drives packet
//            controls and observes the line outputs.
//   slave  : the line driver itself.
//   Signals:
//     tx_data_valid  packet bits pending; falling low requests EOP
//     nrzi_data      current NRZI bit (1 = J, 0 = K)
//     ls_mode        low-speed polarity select
//     force_se0      hold SE0 while idle (bus reset)
//     tx_bit_req     one-cycle pulse after each bit sample
//     txd_pos/neg    D+/D- pad drive
//     txd_oe         pad driver enable
//     tx_busy        packet or EOP in progress
interface usb_tx_line_driver_if;
  logic tx_data_valid;
  logic nrzi_data;
  logic ls_mode;
  logic force_se0;
  logic tx_bit_req;
  logic txd_pos;
  logic txd_neg;
  logic txd_oe;
  logic tx_busy;

  modport master (
    output tx_data_valid, nrzi_data, ls_mode, force_se0,
    input  tx_bit_req, txd_pos, txd_neg, txd_oe, tx_busy
  );

  modport slave (
    input  tx_data_valid, nrzi_data, ls_mode, force_se0,
    output tx_bit_req, txd_pos, txd_neg, txd_oe, tx_busy
  );
endinterface

// File: rtl/usb_tx_line_driver.sv
// usb_tx_line_driver
//   Converts an NRZI bit stream into the D+/D- pair, one bit every CLK_DIV
//   gclk cycles, with FS/LS polarity, automatic EOP (SE0 then J), driver
//   enable and idle SE0 forcing for bus reset.
//   Parameters:
//     CLK_DIV       gclk cycles per bit time (>= 2)
//     EOP_SE0_BITS  SE0 bit times in an EOP (1..3)
//   Ports:
//     gclk   clock, rising edge
//     reset  synchronous active-high reset
//     bus    usb_tx_line_driver_if.slave (handshake + pad outputs)
module usb_tx_line_driver #(
  parameter int CLK_DIV      = 4,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic                  gclk,
  input  logic                  reset,
  usb_tx_line_driver_if.slave   bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, DATA, EOP_SE0, EOP_J} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [1:0]         eop_q, eop_d;
  logic               ls_q, ls_d;
  logic [1:0]         line_q, line_d;   // {pos, neg}
  logic               oe_q, oe_d;
  logic               req_q, req_d;
  logic               busy_q, busy_d;
  logic               bit_end;
  logic               eop_last;

  // {pos,neg} for an NRZI bit: FS J=10 K=01, LS swaps the pair.
  function automatic logic [1:0] line_code(input logic bit_val, input logic ls);
    return {bit_val ^ ls, ~(bit_val ^ ls)};
  endfunction

  assign bit_end  = (div_q == DIV_W'(CLK_DIV - 1));
  assign eop_last = (eop_q == 2'(EOP_SE0_BITS - 1));

  always_ff @(posedge gclk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!bus.force_se0 && bus.tx_data_valid) state_d = DATA;
      DATA:    if (bit_end && !bus.tx_data_valid)       state_d = EOP_SE0;
      EOP_SE0: if (bit_end && eop_last)                 state_d = EOP_J;
      EOP_J:   if (bit_end)                             state_d = IDLE;
      default:                                          state_d = IDLE;
    endcase
  end

  always_comb begin
    line_d = line_q;
    oe_d   = oe_q;
    req_d  = 1'b0;
    ls_d   = ls_q;
    eop_d  = eop_q;
    busy_d = (state_d != IDLE);
    div_d  = bit_end ? '0 : div_q + DIV_W'(1);
    unique case (state_q)
      IDLE: begin
        div_d = '0;
        if (bus.force_se0) begin
          line_d = 2'b00;
          oe_d   = 1'b1;
        end else if (bus.tx_data_valid) begin
          // Polarity comes straight from ls_mode on the start edge, since
          // ls_q only takes the new value on this same edge.
          ls_d   = bus.ls_mode;
          line_d = line_code(bus.nrzi_data, bus.ls_mode);
          oe_d   = 1'b1;
          req_d  = 1'b1;
        end else begin
          line_d = line_code(1'b1, bus.ls_mode);
          oe_d   = 1'b0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bus.tx_data_valid) begin
            line_d = line_code(bus.nrzi_data, ls_q);
            req_d  = 1'b1;
          end else begin
            line_d = 2'b00;
            eop_d  = '0;
          end
        end
      end
      EOP_SE0: begin
        if (bit_end) begin
          eop_d = eop_q + 2'd1;
          if (eop_last) line_d = line_code(1'b1, ls_q);
        end
      end
      EOP_J: begin
        if (bit_end) oe_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge gclk) begin
    if (reset) begin
      div_q  <= '0;
      eop_q  <= '0;
      ls_q   <= 1'b0;
      line_q <= 2'b00;
      oe_q   <= 1'b0;
      req_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      eop_q  <= eop_d;
      ls_q   <= ls_d;
      line_q <= line_d;
      oe_q   <= oe_d;
      req_q  <= req_d;
      busy_q <= busy_d;
    end
  end

  assign bus.txd_pos    = line_q[1];
  assign bus.txd_neg    = line_q[0];
  assign bus.txd_oe     = oe_q;
  assign bus.tx_bit_req = req_q;
  assign bus.tx_busy    = busy_q;

endmodule

// File: tb/tb_usb_tx_line_driver.sv
module tb_usb_tx_line_driver;
  localparam int CLK_DIV  = 4;
  localparam int EOP_BITS = 2;

  logic gclk;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  usb_tx_line_driver_if bus ();

  usb_tx_line_driver #(.CLK_DIV(CLK_DIV), .EOP_SE0_BITS(EOP_BITS)) dut (
    .gclk  (gclk),
    .reset (reset),
    .bus   (bus)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  // Line pair for a bit value under a given polarity, straight from the
  // J/K table: FS J=10 K=01, LS J=01 K=10.
  function automatic logic [1:0] line(input bit b, input bit ls);
    if (!ls) return b ? 2'b10 : 2'b01;
    else     return b ? 2'b01 : 2'b10;
  endfunction

  // Observed outputs packed as {pos, neg, oe, req, busy}.
  function automatic logic [4:0] obs();
    return {bus.txd_pos, bus.txd_neg, bus.txd_oe, bus.tx_bit_req, bus.tx_busy};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Sends bits pat[0..n-1] starting at the next edge, and checks every cycle
  // against the expected timeline: n bit times, EOP_BITS bit times of SE0,
  // one bit time of J, then idle. Non-boundary inputs are randomised because
  // the driver must ignore them. abort_c >= 0 asserts reset during that cycle.
  task automatic run_packet(input string tag, input bit [31:0] pat, input int n,
                            input bit ls, input bit ls_toggle, input int abort_c);
    int data_c = n * CLK_DIV;
    int se0_c  = EOP_BITS * CLK_DIV;
    int end_c  = data_c + se0_c + CLK_DIV;
    int oe_cnt = 0;
    int nxt;
    logic [4:0] exp;
    bus.force_se0     = 1'b0;
    bus.tx_data_valid = 1'b1;
    bus.nrzi_data     = pat[0];
    bus.ls_mode       = ls;
    for (int c = 0; c <= end_c + 1; c++) begin
      @(negedge gclk);
      if (c < data_c)              exp = {line(pat[c / CLK_DIV], ls), 1'b1, (c % CLK_DIV) == 0, 1'b1};
      else if (c < data_c + se0_c) exp = 5'b00_1_0_1;
      else if (c < end_c)          exp = {line(1'b1, ls), 3'b1_0_1};
      else                         exp = {line(1'b1, ls), 3'b0_0_0};
      check(tag, 32'(obs()), 32'(exp));
      if (bus.txd_oe) oe_cnt++;
      if (c == abort_c) begin
        reset = 1'b1;
        bus.tx_data_valid = 1'b0;
        bus.force_se0 = 1'b0;
        bus.ls_mode = ls;
        @(negedge gclk);
        check({tag, "_reset"}, 32'(obs()), 32'd0);
        reset = 1'b0;
        @(negedge gclk);
        check({tag, "_after_reset"}, 32'(obs()), 32'({line(1'b1, ls), 3'b000}));
        return;
      end
      nxt = c + 1;
      if (nxt >= end_c) begin
        bus.tx_data_valid = 1'b0;
        bus.force_se0     = 1'b0;
        bus.ls_mode       = ls;
      end else begin
        if (nxt % CLK_DIV == 0 && nxt <= data_c) begin
          bus.tx_data_valid = (nxt < data_c);
          bus.nrzi_data     = (nxt < data_c) ? pat[nxt / CLK_DIV] : 1'($urandom);
        end else begin
          bus.tx_data_valid = 1'($urandom);
          bus.nrzi_data     = 1'($urandom);
        end
        if (nxt > data_c) bus.force_se0 = 1'($urandom);
        bus.ls_mode = ls_toggle ? 1'($urandom) : ls;
      end
    end
    check({tag, "_oe_len"}, 32'(oe_cnt), 32'(end_c));
  endtask

  initial begin
    reset             = 1'b1;
    bus.tx_data_valid = 1'b0;
    bus.nrzi_data     = 1'b0;
    bus.ls_mode       = 1'b0;
    bus.force_se0     = 1'b0;

    // Reset values, then idle J in FS.
    repeat (3) @(negedge gclk);
    check("in_reset", 32'(obs()), 32'd0);
    reset = 1'b0;
    @(negedge gclk);
    check("idle_fs", 32'(obs()), 32'(5'b10_0_0_0));

    // ls_mode change while idle shows one cycle later.
    bus.ls_mode = 1'b1;
    @(negedge gclk);
    check("idle_ls", 32'(obs()), 32'(5'b01_0_0_0));
    bus.ls_mode = 1'b0;
    @(negedge gclk);
    check("idle_fs_again", 32'(obs()), 32'(5'b10_0_0_0));

    // Directed FS and LS packets of bits 1,0,1,1; LS run toggles ls_mode.
    run_packet("fs_1011", 32'hD, 4, 1'b0, 1'b0, -1);
    run_packet("ls_1011", 32'hD, 4, 1'b1, 1'b1, -1);

    // Single-bit packet.
    run_packet("single_bit", 32'h0, 1, 1'b0, 1'b0, -1);

    // force_se0 beats tx_data_valid while idle; packet starts once it drops.
    bus.force_se0     = 1'b1;
    bus.tx_data_valid = 1'b1;
    bus.nrzi_data     = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge gclk);
      check("force_se0", 32'(obs()), 32'(5'b00_1_0_0));
    end
    run_packet("after_force", 32'h5, 3, 1'b0, 1'b0, -1);

    // Reset on the 3rd cycle of EOP_SE0 aborts without finishing the EOP.
    run_packet("eop_abort", 32'h3, 2, 1'b0, 1'b0, 2 * CLK_DIV + 2);

    // Randomised packets.
    for (int i = 0; i < 8; i++) begin
      int n;
      bit [31:0] pat;
      bit ls;
      n   = int'($urandom_range(1, 12));
      pat = $urandom;
      ls  = 1'($urandom);
      run_packet("rand_pkt", pat, n, ls, 1'b1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/usb_tx_line_driver.md
# usb_tx_line_driver

Parametrised USB transmit line driver that replaces the single-rate differential driver. It converts an NRZI bit stream into the D+/D- pair, paced by an internal bit-rate divider. It also supports full-speed and low-speed J/K polarity, generates the EOP automatically, provides a driver output-enable, and drives SE0 on request for bus-reset signalling. It sits between the NRZI encoder/bit-stuffer and the transceiver pads.

## Interface
- CLK_DIV, 4, gclk cycles per bit time; legal values are 2 and above. The counter is $clog2(CLK_DIV) bits wide.
- EOP_SE0_BITS, 2, number of SE0 bit times in an EOP; legal range 1-3.
- gclk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- tx_data_valid  in  1  high while the upstream has packet bits to send; falling low requests the EOP.
- nrzi_data  in  1  current NRZI bit (1 = J, 0 = K); sampled only at bit boundaries.
- ls_mode  in  1  1 = low-speed polarity; latched at packet start and ignored otherwise.
- force_se0  in  1  drive SE0 while idle (bus reset).
- tx_bit_req  out  1  one-cycle pulse the cycle after nrzi_data was sampled; upstream presents the next bit within CLK_DIV-1 cycles.
- txd_pos  out  1  D+ (registered).
- txd_neg  out  1  D- (registered).
- txd_oe  out  1  driver enable (registered).
- tx_busy  out  1  high in DATA, EOP_SE0 and EOP_J.

## Operation
- Line encoding (ls_q = latched ls_mode):
  - FS: J = (pos,neg) = (1,0); K = (0,1).
  - LS: J = (0,1); K = (1,0).
  - SE0 = (0,0) in both modes.
- States: IDLE, DATA, EOP_SE0, EOP_J.
- Reset: state goes to IDLE; txd_pos=0, txd_neg=0, txd_oe=0, tx_bit_req=0, tx_busy=0, div_cnt=0, eop_cnt=0, ls_q=0.
- IDLE:
  - div_cnt is held at 0.
  - If force_se0=1, lines go to SE0 and txd_oe=1. force_se0 has priority over tx_data_valid, so the packet start is deferred.
  - Otherwise, if tx_data_valid=1: ls_q<=ls_mode, sample nrzi_data onto the lines, txd_oe<=1, pulse tx_bit_req, go to DATA.
  - Otherwise, the lines show J for the current ls_mode and txd_oe=0.
- DATA:
  - div_cnt increments modulo CLK_DIV.
  - At div_cnt==CLK_DIV-1 with tx_data_valid=1: sample nrzi_data onto the lines and pulse tx_bit_req.
  - At div_cnt==CLK_DIV-1 with tx_data_valid=0: lines go to SE0, eop_cnt<=0, go to EOP_SE0.
  - tx_data_valid is examined only at bit boundaries.
- EOP_SE0:
  - SE0 is held for EOP_SE0_BITS*CLK_DIV cycles, with eop_cnt counting bit times.
  - Then the lines go to J (ls_q polarity) and the state moves to EOP_J.
- EOP_J:
  - J is held for CLK_DIV cycles with txd_oe=1.
  - Then txd_oe<=0 and the state moves to IDLE.
- No tx_bit_req pulses occur in the EOP states. force_se0 and tx_data_valid are ignored in EOP_SE0 and EOP_J.
- A new packet may start on the first IDLE cycle after EOP_J.
- reset asserted in any state takes effect on the next edge, with no EOP emitted.

## Timing
- Latency: tx_data_valid sampled high in IDLE → first bit on the lines, txd_oe=1 and tx_bit_req=1 on the following cycle.
- Every bit is held exactly CLK_DIV cycles, and tx_bit_req pulses are exactly CLK_DIV cycles apart.
- For a packet of N bits, txd_oe stays high for N*CLK_DIV + EOP_SE0_BITS*CLK_DIV + CLK_DIV contiguous cycles.
- tx_busy is registered and asserted on the same cycles as the DATA/EOP line values.
- ls_mode and force_se0 changes in IDLE appear on the lines one cycle later.

## Test plan
- Reset, then idle with ls_mode=0 → pos/neg/oe=0/0/0 during reset; 1/0/0 one cycle after release; tx_busy=0.
- FS packet of bits 1,0,1,1, tx_data_valid dropped after the 4th tx_bit_req (CLK_DIV=4):
  - lines 10,01,10,10 for 4 cycles each;
  - four tx_bit_req pulses spaced 4 cycles apart;
  - then SE0 for 8 cycles and J(10) for 4 cycles;
  - txd_oe high for exactly 28 cycles, then 0.
- Same stream with ls_mode=1 → lines 01,10,01,01, SE0 for 8 cycles, J=01 for 4 cycles. Toggling ls_mode mid-packet changes nothing.
- force_se0=1 for 10 idle cycles with tx_data_valid=1 → lines 00, oe=1, no tx_bit_req. The packet starts one cycle after force_se0 falls.
- Reset asserted on the 3rd cycle of EOP_SE0 → next edge: lines 00, oe=0, tx_busy=0, state IDLE.
- Single-bit packet (tx_data_valid low at the first bit boundary) → one bit of 4 cycles, one tx_bit_req pulse, full EOP; total oe-high time 16 cycles.
